hsync_monitor: RTL and testbench

Receive-side checker for the horizontal timing chain. It samples HBLANK and HSYNC once per pixel-clock enable and measures each line's total length, blank width and sync position. It declares lock once the timing matches the nominal 320/64 line, and regenerates an active-pixel X coordinate from the received blank edges. It sits downstream of the sync chain and feeds the video overlay/scan-doubler path and the debug status registers.

---
 rtl/hsync_monitor.sv | 162 ++++++++++++++++
 tb/tb_hsync_monitor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hsync_monitor.sv
// Horizontal timing checker: measures line/blank/sync timing per pixel enable,
// tracks lock against the nominal line, and regenerates the active-pixel X.
//
// state   | meaning
// HUNT    | waiting for the first HBLANK rise; nothing is evaluated
// MEASURE | evaluating lines, counting consecutive good ones towards lock
// LOCKED  | timing locked; consecutive bad lines drop back to MEASURE
module hsync_monitor #(
    parameter int LINE_LEN     = 320,
    parameter int BLANK_LEN    = 64,
    parameter int TOL          = 1,
    parameter int LOCK_LINES   = 4,
    parameter int UNLOCK_LINES = 2
) (
    input  logic       CLK10,
    input  logic       RESET,
    input  logic       PIXCE,
    input  logic       HBLANK_IN,
    input  logic       HSYNC_IN,
    output logic       locked,
    output logic       line_strobe,
    output logic [8:0] line_len,
    output logic [8:0] blank_len,
    output logic [8:0] sync_start,
    output logic [7:0] err_cnt,
    output logic [7:0] x,
    output logic       x_valid
);

    typedef enum logic [1:0] {HUNT, MEASURE, LOCKED} state_t;

    localparam logic [9:0] LINE_MIN    = 10'(LINE_LEN - TOL);
    localparam logic [9:0] LINE_MAX    = 10'(LINE_LEN + TOL);
    localparam logic [9:0] BLANK_MIN   = 10'(BLANK_LEN - TOL);
    localparam logic [9:0] BLANK_MAX   = 10'(BLANK_LEN + TOL);
    localparam logic [7:0] GOOD_TARGET = 8'(LOCK_LINES);
    localparam logic [7:0] BAD_TARGET  = 8'(UNLOCK_LINES);

    state_t     state;
    logic [8:0] pix_cnt;
    logic       hb_q;
    logic       hs_q;
    logic       sync_seen;
    logic [7:0] good_cnt;
    logic [7:0] bad_cnt;

    logic       hb_rise;
    logic       hb_fall;
    logic       hs_rise;
    logic       timeout;
    logic       line_ok;
    logic [8:0] cnt_inc;
    logic [7:0] err_inc;

    always_comb begin
        hb_rise = PIXCE & HBLANK_IN & ~hb_q;
        hb_fall = PIXCE & ~HBLANK_IN & hb_q;
        hs_rise = PIXCE & HSYNC_IN & ~hs_q;
        // cnt_inc is the sample's offset from the last rise, as seen after this sample
        cnt_inc = (pix_cnt == 9'd511) ? 9'd511 : pix_cnt + 9'd1;
        timeout = PIXCE & ~hb_rise & (pix_cnt == 9'd510);
        line_ok = ({1'b0, cnt_inc} >= LINE_MIN) && ({1'b0, cnt_inc} <= LINE_MAX) &&
                  ({1'b0, blank_len} >= BLANK_MIN) && ({1'b0, blank_len} <= BLANK_MAX) &&
                  sync_seen;
        err_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    end

    assign x_valid = locked & ~hb_q;

    always_ff @(posedge CLK10) begin
        if (RESET) begin
            state       <= HUNT;
            pix_cnt     <= '0;
            hb_q        <= 1'b0;
            hs_q        <= 1'b0;
            sync_seen   <= 1'b0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            locked      <= 1'b0;
            line_strobe <= 1'b0;
            line_len    <= '0;
            blank_len   <= '0;
            sync_start  <= '0;
            err_cnt     <= '0;
            x           <= '0;
        end else begin
            line_strobe <= 1'b0;
            if (PIXCE) begin
                hb_q    <= HBLANK_IN;
                hs_q    <= HSYNC_IN;
                pix_cnt <= hb_rise ? 9'd0 : cnt_inc;

                if (hb_fall) begin
                    blank_len <= cnt_inc;
                    x         <= '0;
                end else if (!hb_q) begin
                    x <= x + 8'd1;
                end

                if (hs_rise)
                    sync_start <= hb_rise ? 9'd0 : cnt_inc;

                // a sync rise on the blank rise belongs to the new line
                if (hb_rise)
                    sync_seen <= hs_rise;
                else if (hs_rise)
                    sync_seen <= 1'b1;

                if (hb_rise) begin
                    line_len <= cnt_inc;
                    case (state)
                        HUNT: begin
                            state    <= MEASURE;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end
                        MEASURE: begin
                            line_strobe <= 1'b1;
                            if (line_ok) begin
                                if (good_cnt + 8'd1 == GOOD_TARGET) begin
                                    state    <= LOCKED;
                                    locked   <= 1'b1;
                                    good_cnt <= '0;
                                    bad_cnt  <= '0;
                                end else begin
                                    good_cnt <= good_cnt + 8'd1;
                                end
                            end else begin
                                good_cnt <= '0;
                                err_cnt  <= err_inc;
                            end
                        end
                        LOCKED: begin
                            line_strobe <= 1'b1;
                            if (line_ok) begin
                                bad_cnt <= '0;
                            end else begin
                                err_cnt <= err_inc;
                                if (bad_cnt + 8'd1 == BAD_TARGET) begin
                                    state    <= MEASURE;
                                    locked   <= 1'b0;
                                    good_cnt <= '0;
                                    bad_cnt  <= '0;
                                end else begin
                                    bad_cnt <= bad_cnt + 8'd1;
                                end
                            end
                        end
                        default: state <= HUNT;
                    endcase
                end else if (timeout) begin
                    state    <= HUNT;
                    locked   <= 1'b0;
                    good_cnt <= '0;
                    bad_cnt  <= '0;
                    err_cnt  <= err_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_hsync_monitor.sv
// Bench for hsync_monitor: lines are described by (length, blank, sync offset)
// and a line-level model predicts the per-rise measurements, lock and errors.
module tb_hsync_monitor;

    localparam int LINE_LEN  = 320;
    localparam int BLANK_LEN = 64;
    localparam int TOL       = 1;
    localparam int LOCK_N    = 4;
    localparam int UNLOCK_N  = 2;

    logic       CLK10 = 1'b0;
    logic       RESET = 1'b0;
    logic       PIXCE = 1'b0;
    logic       HBLANK_IN = 1'b0;
    logic       HSYNC_IN = 1'b0;
    logic       locked;
    logic       line_strobe;
    logic [8:0] line_len;
    logic [8:0] blank_len;
    logic [8:0] sync_start;
    logic [7:0] err_cnt;
    logic [7:0] x;
    logic       x_valid;

    hsync_monitor #(
        .LINE_LEN(LINE_LEN), .BLANK_LEN(BLANK_LEN), .TOL(TOL),
        .LOCK_LINES(LOCK_N), .UNLOCK_LINES(UNLOCK_N)
    ) dut (
        .CLK10(CLK10), .RESET(RESET), .PIXCE(PIXCE),
        .HBLANK_IN(HBLANK_IN), .HSYNC_IN(HSYNC_IN),
        .locked(locked), .line_strobe(line_strobe), .line_len(line_len),
        .blank_len(blank_len), .sync_start(sync_start), .err_cnt(err_cnt),
        .x(x), .x_valid(x_valid)
    );

    always #50 CLK10 = ~CLK10;

    int n_checks = 0;
    int n_errors = 0;
    int strobe_seen = 0;

    // model: 0 = hunting, 1 = measuring, 2 = locked
    int m_state, m_good, m_bad, m_err, exp_strobes;
    int p_len, p_blank, p_sync;

    always @(posedge CLK10) if (line_strobe) strobe_seen <= strobe_seen + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK10);
        #1;
    endtask

    function automatic void err_bump();
        if (m_err < 255) m_err++;
    endfunction

    task automatic drive(input logic hb, input logic hs);
        PIXCE = 1'b0;
        repeat (($urandom_range(0, 7) == 0) ? 2 : 1) tick();
        HBLANK_IN = hb;
        HSYNC_IN  = hs;
        PIXCE     = 1'b1;
        tick();
        PIXCE = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1; PIXCE = 1'b1; HBLANK_IN = 1'b1; HSYNC_IN = 1'b1;
        tick();
        RESET = 1'b0; PIXCE = 1'b0; HBLANK_IN = 1'b0; HSYNC_IN = 1'b0;
        m_state = 0; m_good = 0; m_bad = 0; m_err = 0;
        chk("rst_locked", locked, 0);
        chk("rst_strobe", line_strobe, 0);
        chk("rst_line_len", line_len, 0);
        chk("rst_blank_len", blank_len, 0);
        chk("rst_sync_start", sync_start, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_x", x, 0);
        chk("rst_x_valid", x_valid, 0);
    endtask

    task automatic rise_step(input int cur_sync);
        bit good;
        int exp_strobe;
        exp_strobe = (m_state != 0) ? 1 : 0;
        if (m_state == 0) begin
            m_state = 1;
        end else begin
            exp_strobes++;
            chk("line_len", line_len, p_len);
            chk("blank_len", blank_len, p_blank);
            if (p_sync >= 0 && cur_sync != 0) chk("sync_start", sync_start, p_sync);
            good = (p_len >= LINE_LEN - TOL) && (p_len <= LINE_LEN + TOL) &&
                   (p_blank >= BLANK_LEN - TOL) && (p_blank <= BLANK_LEN + TOL) &&
                   (p_sync >= 0);
            if (m_state == 1) begin
                if (good) begin
                    m_good++;
                    if (m_good == LOCK_N) begin m_state = 2; m_bad = 0; m_good = 0; end
                end else begin
                    m_good = 0;
                    err_bump();
                end
            end else begin
                if (good) m_bad = 0;
                else begin
                    m_bad++;
                    err_bump();
                    if (m_bad == UNLOCK_N) begin m_state = 1; m_good = 0; m_bad = 0; end
                end
            end
        end
        chk("rise_strobe", line_strobe, exp_strobe);
        chk("rise_locked", locked, (m_state == 2) ? 1 : 0);
        chk("rise_err_cnt", err_cnt, m_err);
    endtask

    // sync_s < 0 means no sync pulse in this line
    task automatic send_line(input int len, input int blank, input int sync_s,
                             input int stall_at, input int abort_at);
        int  xv;
        bit  tmo;
        logic hb, hs;
        logic [7:0] hold_x;
        logic [8:0] hold_len;
        logic [7:0] hold_err;
        xv = 0;
        tmo = 0;
        for (int o = 0; o < len; o++) begin
            if (o == abort_at) begin
                do_reset();
                return;
            end
            if (o == stall_at) begin
                hold_x = x; hold_len = line_len; hold_err = err_cnt;
                PIXCE = 1'b0;
                repeat (10) tick();
                chk("stall_x", x, hold_x);
                chk("stall_line_len", line_len, hold_len);
                chk("stall_err_cnt", err_cnt, hold_err);
                chk("stall_locked", locked, (m_state == 2) ? 1 : 0);
            end
            hb = (o < blank);
            hs = (sync_s >= 0) && (o >= sync_s) && (o < sync_s + 8);
            drive(hb, hs);
            if (o == 0) begin
                rise_step(sync_s);
            end else begin
                if (o == 511) begin
                    m_state = 0; m_good = 0; m_bad = 0;
                    err_bump();
                    tmo = 1;
                    chk("timeout_locked", locked, 0);
                    chk("timeout_err_cnt", err_cnt, m_err);
                end
                if (x_valid) xv++;
            end
        end
        chk("x_last", x, (len - blank - 1) & 255);
        if (!tmo) chk("x_valid_cnt", xv, (m_state == 2) ? len - blank : 0);
        p_len = len; p_blank = blank; p_sync = sync_s;
    endtask

    task automatic nominal(input int n);
        for (int i = 0; i < n; i++) send_line(LINE_LEN, BLANK_LEN, 16, -1, -1);
    endtask

    initial begin
        exp_strobes = 0;
        p_len = 0; p_blank = 0; p_sync = -1;
        do_reset();
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0);

        nominal(6);
        chk("nominal_locked", locked, 1);
        chk("nominal_err", err_cnt, 0);

        send_line(321, 64, 16, -1, -1);
        send_line(322, 64, 16, -1, -1);
        send_line(320, 64, 16, -1, -1);
        send_line(322, 64, 16, -1, -1);
        send_line(322, 64, 16, -1, -1);
        send_line(320, 64, 16, -1, -1);
        nominal(5);

        send_line(320, 64, -1, -1, -1);
        send_line(320, 64, -1, -1, -1);
        nominal(6);

        send_line(664, 64, 16, -1, -1);
        nominal(6);

        send_line(320, 64, 0, 200, -1);
        send_line(320, 64, 16, -1, 250);
        for (int i = 0; i < 30; i++) drive(1'b0, 1'b0);
        nominal(6);

        for (int i = 0; i < 20; i++) begin
            int len, blank, s;
            len   = ($urandom_range(0, 2) == 0) ? 318 + $urandom_range(0, 4) : 320;
            blank = ($urandom_range(0, 2) == 0) ? 62 + $urandom_range(0, 4) : 64;
            s     = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 40);
            send_line(len, blank, s, -1, -1);
        end

        tick();
        chk("strobe_total", strobe_seen, exp_strobes);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
